dmem_arbiter: RTL
=================

# dmem_arbiter

Two-master arbiter placed between the single-cycle core and the data memory in `xgriscv_sc`. The core is the default owner. A host port (debug/loader/DMA) gets memory cycles opportunistically when the core is idle, and by forced takeover after a bounded starvation interval. During a takeover the core is stalled. The arbiter owns the dmem port and returns read data to whichever master holds the memory that cycle.

## Interface
Parameters:
- `STARVE_MAX`, 8: contended cycles a pending host request waits before forced takeover (≥2).
- `BURST_MAX`, 4: maximum host beats per takeover (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `core_W_en`, `core_R_en`  in  1  core write/read request.
- `core_addr`  in  32  core address.
- `core_RW_type`  in  3  core access width/sign, encoding per `define.v`.
- `core_wdata`  in  32  core store data.
- `core_rdata`  out  32  core load data.
- `core_stall`  out  1  core must hold PC, request and writeback.
- `host_valid`  in  1  host request pending.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  32  host address.
- `host_RW_type`  in  3  host access type.
- `host_wdata`  in  32  host store data.
- `host_ready`  out  1  host beat accepted this cycle.
- `host_rvalid`  out  1  registered read response valid.
- `host_rdata`  out  32  registered read data.
- `mem_W_en`, `mem_R_en`  out  1  to dmem.
- `mem_addr`  out  32  to dmem.
- `mem_RW_type`  out  3  to dmem.
- `mem_din`  out  32  to dmem.
- `mem_dout`  in  32  from dmem. Combinational read; writes commit on the `clk` edge.

## Operation
- `core_req` = `core_W_en | core_R_en`. `contend` = `host_valid & core_req`.
- States:
  - **CORE_OWN** (reset state): the memory mux selects the core.
    - If `host_valid & ~core_req`, the host is muxed in for that cycle: `host_ready`=1, no stall, state unchanged, `starve_cnt` cleared.
    - If `contend`, `starve_cnt` increments. When `contend` holds with `starve_cnt == STARVE_MAX-1`, go to HOST_OWN and clear `starve_cnt`.
    - If `host_valid`=0, `starve_cnt` clears.
  - **HOST_OWN**: the memory mux selects the host. `host_ready` = `host_valid`. `core_stall` = `core_req`.
    - `beat_cnt` increments on each accepted beat.
    - Return to CORE_OWN after an accepted beat with `beat_cnt == BURST_MAX-1`, or in any cycle with `host_valid`=0. Clear `beat_cnt` on exit.
- `core_stall` is 0 in CORE_OWN.
- `core_rdata` = `mem_dout` when the core is muxed in, otherwise 0.
- Memory enables come from the selected master. The unselected master's enables are never forwarded.
- On an accepted host read (`host_ready & ~host_we`), `host_rdata` <= `mem_dout` and `host_rvalid` <= 1 for exactly the next cycle. Accepted host writes produce no response.
- Host handshake: `host_valid` and all `host_*` fields stay stable until `host_ready`. A beat transfers on `host_valid & host_ready`. The host may deassert `host_valid` only after acceptance.
- The core's request stays stable while `core_stall`=1. The arbiter does not buffer core requests.

## Timing
- Arbitration and muxing are combinational from the inputs and the state. Stall and ready are valid in the same cycle as the request.
- Worst-case host wait under continuous contention: exactly `STARVE_MAX` cycles, with service beginning in cycle `STARVE_MAX`.
- Maximum continuous core stall: `BURST_MAX` cycles per takeover. The core is then guaranteed at least one cycle before the next takeover, because `starve_cnt` restarts from 0.
- Host read latency: data 1 cycle after acceptance. Back-to-back reads give back-to-back `host_rvalid`.
- Reset values: state CORE_OWN, `starve_cnt`=0, `beat_cnt`=0, `host_rvalid`=0, `host_rdata`=0, `host_ready`=0, `core_stall`=0.
- While `reset`=1, `mem_W_en` and `mem_R_en` are forced to 0.
- A reset during HOST_OWN aborts the burst. The host beat in the reset cycle is not accepted.

## Structure
- Shared package/header: state encoding (`ARB_CORE_OWN`, `ARB_HOST_OWN`) and the RW_type constants, which are already in `define.v`.
- Natural sub-module: `dmem_arb_starve_cnt`, a clog2-width counter with clear, enable and terminal flag, instantiated twice (starvation count and beat count).
- Everything else is a single always block for the state and registers, plus a combinational mux.

## Test plan
- **Core-only traffic.** Core stores 0xDEADBEEF to 0x10, then loads it back; host idle. Expect `core_stall`=0 throughout and `core_rdata`=0xDEADBEEF.
- **Opportunistic host access.** Host write of 0x12345678 to 0x20 while core is idle. Expect `host_ready`=1 in the same cycle, no stall, and memory updated.
- **Forced takeover.** `STARVE_MAX`=4, `BURST_MAX`=2; core_req and a host read held continuously. Expect `host_ready` first in cycle 4, `core_stall`=1 in cycles 4–5, and `host_rvalid` in cycles 5–6 with the correct data.
- **Early burst exit.** During HOST_OWN, host drops `host_valid` after 1 beat. Expect return to CORE_OWN the next cycle and `core_stall`=0.
- **Reset mid-burst.** Assert `reset` while in HOST_OWN with a host write pending. Expect the write not committed, all outputs at their reset values, and state CORE_OWN after release.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the arbiter state encoding, the access width/sign codes that the
// core and host drive on their RW_type fields, and a width helper for the
// small cycle counters.
package dmem_arbiter_pkg;

   typedef enum logic {
      ARB_CORE_OWN = 1'b0,
      ARB_HOST_OWN = 1'b1
   } arb_state_e;

   // Load/store width codes; stores reuse the LB/LH/LW codes for SB/SH/SW.
   localparam logic [2:0] RW_LB  = 3'b000;
   localparam logic [2:0] RW_LH  = 3'b001;
   localparam logic [2:0] RW_LW  = 3'b010;
   localparam logic [2:0] RW_LBU = 3'b100;
   localparam logic [2:0] RW_LHU = 3'b101;

   // Counter width able to hold 0..max-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max);
      return (max > 1) ? $clog2(max) : 1;
   endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Small cycle counter used by the arbiter for both the host starvation
// count and the takeover beat count.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   clr        : return the count to 0 (wins over en)
//   en         : advance the count by one
//   tc         : count currently equals MAX-1
module dmem_arb_starve_cnt
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX = 8
)
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned W    = cnt_width(MAX);
   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter between the single-cycle core and dmem.
// The core owns memory by default; the host is slipped in whenever the core
// is idle, and takes the memory over (stalling the core) after it has been
// starved for STARVE_MAX contended cycles, for at most BURST_MAX beats.
//
// Ports:
//   clk, reset                 : system clock, synchronous active-high reset
//   core_W_en/R_en/addr/RW_type/wdata -> core request; core_rdata, core_stall back
//   host_valid/we/addr/RW_type/wdata  -> host request; host_ready accepts a beat
//   host_rvalid/host_rdata     : registered read response, one cycle after accept
//   mem_W_en/R_en/addr/RW_type/din -> dmem; mem_dout <- dmem (combinational read)
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ARB_CORE_OWN | core selected; host muxed in only when the core is idle
// ARB_HOST_OWN | forced takeover; host selected, core stalled if requesting
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8,
   parameter int unsigned BURST_MAX  = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        core_W_en,
   input  logic        core_R_en,
   input  logic [31:0] core_addr,
   input  logic [2:0]  core_RW_type,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   input  logic        host_valid,
   input  logic        host_we,
   input  logic [31:0] host_addr,
   input  logic [2:0]  host_RW_type,
   input  logic [31:0] host_wdata,
   output logic        host_ready,
   output logic        host_rvalid,
   output logic [31:0] host_rdata,
   output logic        mem_W_en,
   output logic        mem_R_en,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_RW_type,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   arb_state_e state, state_nxt;

   logic core_req;
   logic contend;
   logic host_mux;
   logic host_rd_acc;
   logic starve_en, starve_clr, starve_tc;
   logic beat_en, beat_clr, beat_tc;

   assign core_req = core_W_en | core_R_en;
   assign contend  = host_valid & core_req;

   dmem_arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (starve_clr),
      .en    (starve_en),
      .tc    (starve_tc)
   );

   dmem_arb_starve_cnt #(.MAX(BURST_MAX)) u_beat_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (beat_clr),
      .en    (beat_en),
      .tc    (beat_tc)
   );

   // host_rdata holds its last value between reads; only rvalid pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ARB_CORE_OWN;
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
      end else begin
         state       <= state_nxt;
         host_rvalid <= host_rd_acc;
         if (host_rd_acc) begin
            host_rdata <= mem_dout;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      host_mux   = 1'b0;
      host_ready = 1'b0;
      core_stall = 1'b0;
      starve_en  = 1'b0;
      starve_clr = 1'b1;
      beat_en    = 1'b0;
      beat_clr   = 1'b1;
      unique case (state)
         ARB_CORE_OWN: begin
            host_mux   = host_valid & ~core_req;
            host_ready = host_mux;
            starve_en  = contend;
            // Clearing on terminal count restarts the next starvation window
            // from 0, which guarantees the core a cycle between takeovers.
            starve_clr = ~contend | starve_tc;
            if (contend && starve_tc) begin
               state_nxt = ARB_HOST_OWN;
            end
         end
         ARB_HOST_OWN: begin
            host_mux   = 1'b1;
            host_ready = host_valid;
            core_stall = core_req;
            beat_en    = host_valid;
            beat_clr   = ~host_valid | beat_tc;
            if (!host_valid || beat_tc) begin
               state_nxt = ARB_CORE_OWN;
            end
         end
         default: begin
            state_nxt = ARB_CORE_OWN;
         end
      endcase
      // The beat presented in a reset cycle is dropped, even mid-burst.
      if (reset) begin
         host_ready = 1'b0;
         core_stall = 1'b0;
      end
   end

   assign host_rd_acc = host_ready & ~host_we;

   assign mem_W_en    = ~reset & (host_mux ? (host_valid &  host_we) : core_W_en);
   assign mem_R_en    = ~reset & (host_mux ? (host_valid & ~host_we) : core_R_en);
   assign mem_addr    = host_mux ? host_addr    : core_addr;
   assign mem_RW_type = host_mux ? host_RW_type : core_RW_type;
   assign mem_din     = host_mux ? host_wdata   : core_wdata;
   assign core_rdata  = host_mux ? 32'h0        : mem_dout;

endmodule
